// File: rtl/matrix_morph3x3.sv
// matrix_morph3x3
//   3x3 grey-scale morphology engine. Each accepted pixel brings in one
//   vertically aligned column (rows y-1, y, y+1) from the line buffer. Once
//   three columns of the current line are held, the window centred on the
//   middle column is reduced with min (erode) or max (dilate) over a cross
//   (5 taps) or square (9 taps) structuring element.
//
//   Optional feature macro: MORPH_BIN_OUT_EN
//     defined   -> dout is all-ones when the reduced value >= THRESH, else 0
//     undefined -> dout is the reduced grey value (THRESH ignored)
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   valid_in   pixel strobe; all other inputs are sampled only when high
//   sol        start-of-line, forces the accepted pixel to column 0
//   din_top    row y-1 pixel
//   din_mid    row y pixel
//   din_bot    row y+1 pixel
//   mode       0 = erode (min), 1 = dilate (max); latched at column 0
//   shape      0 = cross, 1 = square; latched at column 0
//   valid_out  one-cycle strobe per result
//   dout       filtered centre pixel, held between results
//
// Timing: a pixel sampled at edge N yields its result at edge N+2
// (window register, then reduction register, then output register).
module matrix_morph3x3 #(
  parameter int WIDTH     = 8,
  parameter int PIC_WIDTH = 250,
  parameter int THRESH    = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             sol,
  input  logic [WIDTH-1:0] din_top,
  input  logic [WIDTH-1:0] din_mid,
  input  logic [WIDTH-1:0] din_bot,
  input  logic             mode,
  input  logic             shape,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout
);

  localparam int CW     = (PIC_WIDTH > 2) ? $clog2(PIC_WIDTH) : 2;
  localparam int STAGES = 2;

`ifdef MORPH_BIN_OUT_EN
  localparam bit BinOut = 1'b1;
`else
  localparam bit BinOut = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] mid;
    logic [WIDTH-1:0] bot;
  } col_t;

  // win_q[0] = right (newest) column, [1] = centre, [2] = left
  col_t [2:0]        win_q;
  logic [CW-1:0]     col_q, col_d, col_cur;
  logic              mode_q, shape_q;
  logic [STAGES:0]   vld_pipe_q;
  logic [WIDTH-1:0]  red_q;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              win_done;

  // Tap order: row-major, index = row*3 + col with col 0 = left.
  // Cross mask selects top_c, mid_l, mid_c, mid_r, bot_c.
  localparam logic [8:0] CrossMask = 9'b010_111_010;

  function automatic logic [WIDTH-1:0] reduce(input col_t [2:0] w,
                                              input logic dil,
                                              input logic sq);
    logic [8:0][WIDTH-1:0] tap;
    logic [WIDTH-1:0]      acc;
    tap[0] = w[2].top; tap[1] = w[1].top; tap[2] = w[0].top;
    tap[3] = w[2].mid; tap[4] = w[1].mid; tap[5] = w[0].mid;
    tap[6] = w[2].bot; tap[7] = w[1].bot; tap[8] = w[0].bot;
    // identity element of the chosen operation
    acc = dil ? '0 : '1;
    for (int i = 0; i < 9; i++) begin
      if (sq || CrossMask[i]) begin
        if (dil) acc = (tap[i] > acc) ? tap[i] : acc;
        else     acc = (tap[i] < acc) ? tap[i] : acc;
      end
    end
    return acc;
  endfunction

  // Column of the pixel currently presented; sol overrides the running count.
  always_comb begin
    col_cur = sol ? '0 : col_q;
    col_d   = col_q;
    if (valid_in) col_d = (col_cur == CW'(PIC_WIDTH - 1)) ? '0 : col_cur + CW'(1);
  end

  // Columns 0 and 1 only fill the window; from column 2 on every pixel
  // completes a window lying wholly inside the current line.
  assign win_done = valid_in && (col_cur >= CW'(2));

  always_comb begin
    dout_d = dout_q;
    if (vld_pipe_q[1]) begin
      if (BinOut) dout_d = ({1'b0, red_q} >= (WIDTH+1)'(THRESH)) ? '1 : '0;
      else        dout_d = red_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      win_q      <= '0;
      mode_q     <= 1'b0;
      shape_q    <= 1'b0;
      vld_pipe_q <= '0;
      red_q      <= '0;
      dout_q     <= '0;
    end else begin
      col_q <= col_d;
      if (valid_in) begin
        win_q <= {win_q[1], win_q[0], col_t'{din_top, din_mid, din_bot}};
        if (col_cur == '0) begin
          mode_q  <= mode;
          shape_q <= shape;
        end
      end
      // valid shift register drains independently of valid_in
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], win_done};
      // window and latched controls are still those of the completing pixel
      // here, even if the next line's column 0 is accepted on this edge
      if (vld_pipe_q[0]) red_q <= reduce(win_q, mode_q, shape_q);
      dout_q <= dout_d;
    end
  end

  assign valid_out = vld_pipe_q[STAGES];
  assign dout      = dout_q;

endmodule
